// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NUM_REQ requesters.
// Define DFF_ARB_LOCK_EN to add the per-requester lock input.
module dff_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data,
`ifdef DFF_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic [OWN_W-1:0]         owner,
  output logic [WIDTH-1:0]         q,
  output logic                     valid
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_GRANT = 1'b1;

  logic               r_state;
  logic [OWN_W-1:0]   r_ptr;
  logic [OWN_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_gnt;
  logic [WIDTH-1:0]   r_q;
  logic               r_valid;

  logic               w_found;
  logic [OWN_W-1:0]   w_sel;
  logic [OWN_W-1:0]   w_nxt_ptr;
  logic [NUM_REQ-1:0] w_onehot;
  logic [WIDTH-1:0]   w_wdata;
  logic               w_wr;
  logic               w_keep;
  int                 w_j;

  // First asserted request at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!w_found && req[w_j[OWN_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_j[OWN_W-1:0];
      end
    end
  end

  assign w_nxt_ptr = (w_sel == OWN_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_onehot  = NUM_REQ'(1) << w_sel;
  assign w_wdata   = data[int'(r_owner)*WIDTH +: WIDTH];
  assign w_wr      = req[r_owner];

`ifdef DFF_ARB_LOCK_EN
  assign w_keep = w_wr & lock[r_owner];
`else
  assign w_keep = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= w_onehot;
            r_owner <= w_sel;
            r_ptr   <= w_nxt_ptr;
          end
        end
        S_GRANT: begin
          r_valid <= w_wr;
          if (w_wr) r_q <= w_wdata;
          // A locked owner keeps gnt, owner and ptr untouched.
          if (!w_keep) begin
            if (w_found) begin
              r_gnt   <= w_onehot;
              r_owner <= w_sel;
              r_ptr   <= w_nxt_ptr;
            end else begin
              r_gnt   <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign q     = r_q;
  assign valid = r_valid;

endmodule

// File: doc/dff_write_arbiter.md
Name: dff_write_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit register, a bank of synchronous DFFs, among NUM_REQ requesters. Each requester raises req with its data. The arbiter grants one requester at a time and loads that requester's data into the shared register q. A one-cycle valid pulse marks each completed write. It sits between the requesting agents and the shared state register.

Parameters:
NUM_REQ, 4, number of requesters; legal range >= 2
WIDTH, 8, width of the shared register and of each data slice
OWN_W, $clog2(NUM_REQ), width of the owner index; derived, not to be overridden

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
req  input  NUM_REQ  per-requester write request; must be held until its gnt bit is seen
data  input  NUM_REQ*WIDTH  packed write data; slice k is data[k*WIDTH +: WIDTH]
gnt  output  NUM_REQ  registered one-hot grant; all zero when idle
owner  output  OWN_W  index of the current or most recent grantee
q  output  WIDTH  shared register contents
valid  output  1  one-cycle pulse, high in the cycle after q is updated by a completed write

Behaviour:
- Reset values: state=IDLE, ptr=0, gnt=0, owner=0, q=0, valid=0.
- Reset is asynchronous: assertion clears every output at once, mid-grant included. The in-flight write is discarded. While reset is high, nothing changes.
- States: IDLE and GRANT.
- Selection: search req starting at index ptr, ascending, wrapping at NUM_REQ-1 to 0. The first asserted bit k wins.
- IDLE, any req high: at the next edge go to GRANT, set gnt=onehot(k), owner=k, ptr=(k+1) mod NUM_REQ.
- IDLE, req=0: stay in IDLE; outputs hold, valid=0.
- GRANT with owner k, req[k] high at the edge: q<=data slice k and valid<=1.
  - Any req still high: re-arbitrate in the same edge from the updated ptr and stay in GRANT with a new gnt and owner.
  - Otherwise: gnt<=0 and go to IDLE.
  - Back-to-back throughput is 1 write per cycle.
- GRANT with owner k, req[k] low at the edge (abort): q unchanged, valid<=0, then re-arbitrate or go to IDLE as above. ptr is not rolled back.
- Latency: req asserted in cycle N (state IDLE) gives gnt in N+1, q updated and valid high in N+2.
- The current owner is re-granted next only when it is the sole requester; round-robin fairness follows from the ptr update.
- gnt is always zero or one-hot, never multi-hot.
- owner holds its last value in IDLE.
- q holds its value indefinitely between writes.

Optional Feature:
Macro DFF_ARB_LOCK_EN.
- Defined: adds input port lock (width NUM_REQ). In GRANT with owner k, if lock[k] and req[k] are both high at the edge, the write completes and k keeps the grant: gnt unchanged, ptr not advanced. This gives k exclusive consecutive writes until lock[k] or req[k] drops. lock bits of non-owners are ignored.
- Undefined: no lock port exists and arbitration is strictly round-robin.

Test Plan:
1. Reset: hold reset=1 with req=4'b1111 -> q=8'h00, gnt=4'b0000, valid=0, owner=0. Release reset with req=0 -> all outputs stay unchanged for 5 cycles.
2. Single write: req=4'b0100, data slice2=8'hA5 -> next cycle gnt=4'b0100, owner=2. Following cycle q=8'hA5, valid=1. With req dropped at the grant edge, the cycle after that has gnt=0 and valid=0.
3. Full contention: req=4'b1111 held, slices 8'h11,8'h22,8'h33,8'h44 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles. q follows one cycle later as 11,22,33,44,11, with valid continuously high.
4. Abort: gnt=4'b0010 with req[1] dropped before the edge and q=8'h5A -> q stays 8'h5A, valid=0, next state IDLE (no other req).
5. Async reset mid-grant: assert reset half a cycle after gnt=4'b1000 -> gnt, q and valid are 0 before the next edge. After release, req=4'b1001 grants index 0 first (ptr=0).
6. Lock (DFF_ARB_LOCK_EN defined): req=4'b1001, lock=4'b1000, first grant index 3 -> gnt=4'b1000 held for 3 writes. Drop lock[3] -> next grant 4'b0001.
